// File: rtl/la_pkg.sv
// Shared definitions for the logic analyzer capture path.
// State encodings are host-visible through the register map and must stay stable.
package la_pkg;

  typedef logic [2:0] la_state_t;

  localparam la_state_t ST_IDLE             = 3'd0;
  localparam la_state_t ST_MOVE_TO_POSITION = 3'd1;
  localparam la_state_t ST_IN_POSITION      = 3'd2;
  localparam la_state_t ST_CAPTURING        = 3'd3;
  localparam la_state_t ST_CAPTURED         = 3'd4;

endpackage

// File: rtl/la_ring_ptr.sv
// Modulo-DEPTH incrementing pointer with synchronous clear and enable.
// The wrap is explicit so DEPTH need not be a power of two.
module la_ring_ptr #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0] ptr_r;

  // Pointer register: clear has priority over advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      ptr_r <= {WIDTH{1'b0}};
    end else if (en) begin
      ptr_r <= (ptr_r == LAST) ? {WIDTH{1'b0}} : ptr_r + WIDTH'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/la_capture_controller.sv
// Write-side sequencer for the logic analyzer sample RAM: pre-trigger fill,
// circular write until trigger, post-trigger fill, then hold for readback.
module la_capture_controller
  import la_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 18,
  parameter int SAMPLE_DEPTH = 1024,
  parameter int TRIGGER_LOC  = 512,
  localparam int ADDR_WIDTH  = $clog2(SAMPLE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    trigger,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [SAMPLE_WIDTH-1:0] bram_din,
  output logic                    bram_we,
  output logic [ADDR_WIDTH-1:0]   read_ptr,
  output logic [2:0]              state,
  output logic                    done
);

  if (TRIGGER_LOC >= SAMPLE_DEPTH || TRIGGER_LOC < 0) begin : g_bad_trigger_loc
    $error("la_capture_controller: TRIGGER_LOC must lie in [0, SAMPLE_DEPTH)");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST       = ADDR_WIDTH'(SAMPLE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] TL_A       = ADDR_WIDTH'(TRIGGER_LOC);
  localparam logic [ADDR_WIDTH-1:0] TL_M1      = ADDR_WIDTH'((TRIGGER_LOC == 0) ? 0 : TRIGGER_LOC - 1);
  localparam logic [ADDR_WIDTH-1:0] D_MINUS_TL = ADDR_WIDTH'(SAMPLE_DEPTH - TRIGGER_LOC);

  la_state_t             state_r;
  la_state_t             state_next_s;
  logic [ADDR_WIDTH-1:0] read_ptr_r;
  logic [ADDR_WIDTH-1:0] pre_cnt_r;
  logic [ADDR_WIDTH-1:0] write_ptr_s;
  logic [ADDR_WIDTH-1:0] wp_inc_s;
  logic [ADDR_WIDTH-1:0] rp_calc_s;
  logic [ADDR_WIDTH-1:0] rp_prev_s;
  logic                  arm_s;
  logic                  trig_hit_s;
  logic                  bram_we_s;
  logic                  done_s;

  assign arm_s      = start && !stop && (state_r == ST_IDLE || state_r == ST_CAPTURED);
  assign trig_hit_s = trigger && !stop && (state_r == ST_IN_POSITION);

  la_ring_ptr #(
    .DEPTH (SAMPLE_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_write_ptr (
    .clk (clk),
    .rst (rst),
    .clr (arm_s),
    .en  (bram_we_s),
    .ptr (write_ptr_s)
  );

  // Modular pointer arithmetic kept in ADDR_WIDTH without relying on overflow.
  always_comb begin
    wp_inc_s  = (write_ptr_s == LAST) ? {ADDR_WIDTH{1'b0}} : write_ptr_s + ADDR_WIDTH'(1);
    rp_prev_s = (read_ptr_r == {ADDR_WIDTH{1'b0}}) ? LAST : read_ptr_r - ADDR_WIDTH'(1);
    if (write_ptr_s >= TL_A) begin
      rp_calc_s = write_ptr_s - TL_A;
    end else begin
      rp_calc_s = write_ptr_s + D_MINUS_TL;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; stop overrides every other request.
  always_comb begin
    state_next_s = state_r;
    if (stop) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_CAPTURED: begin
          if (start) begin
            state_next_s = (TRIGGER_LOC == 0) ? ST_IN_POSITION : ST_MOVE_TO_POSITION;
          end else begin
            state_next_s = state_r;
          end
        end
        ST_MOVE_TO_POSITION: begin
          if (pre_cnt_r == TL_M1) begin
            state_next_s = ST_IN_POSITION;
          end else begin
            state_next_s = ST_MOVE_TO_POSITION;
          end
        end
        ST_IN_POSITION: begin
          if (!trigger) begin
            state_next_s = ST_IN_POSITION;
          end else if (wp_inc_s == rp_calc_s) begin
            state_next_s = ST_CAPTURED;
          end else begin
            state_next_s = ST_CAPTURING;
          end
        end
        ST_CAPTURING: begin
          if (write_ptr_s == rp_prev_s) begin
            state_next_s = ST_CAPTURED;
          end else begin
            state_next_s = ST_CAPTURING;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    bram_we_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_MOVE_TO_POSITION, ST_IN_POSITION, ST_CAPTURING: bram_we_s = !stop;
      ST_CAPTURED:                                       done_s    = 1'b1;
      default:                                           bram_we_s = 1'b0;
    endcase
  end

  // Pre-trigger counter and read pointer latched at the trigger sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_r  <= {ADDR_WIDTH{1'b0}};
      read_ptr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (arm_s) begin
        pre_cnt_r <= {ADDR_WIDTH{1'b0}};
      end else if (bram_we_s && state_r == ST_MOVE_TO_POSITION) begin
        pre_cnt_r <= pre_cnt_r + ADDR_WIDTH'(1);
      end else begin
        pre_cnt_r <= pre_cnt_r;
      end
      if (trig_hit_s) begin
        read_ptr_r <= rp_calc_s;
      end else begin
        read_ptr_r <= read_ptr_r;
      end
    end
  end

  assign bram_addr = write_ptr_s;
  assign bram_din  = sample_in;
  assign bram_we   = bram_we_s;
  assign read_ptr  = read_ptr_r;
  assign state     = state_r;
  assign done      = done_s;

endmodule

// File: tb/tb_la_capture_controller.sv
// Directed bench for la_capture_controller: D=16/TL=4 main instance plus
// TL=0, TL=15 and D=12 variants sharing the same stimulus.
module tb_la_capture_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        trigger = 1'b0;
  logic [17:0] sample_in = 18'd0;

  logic [3:0]  addr_a, rp_a, addr_z, rp_z, addr_f, rp_f, addr_t, rp_t;
  logic [17:0] din_a, din_z, din_f, din_t;
  logic        we_a, we_z, we_f, we_t, done_a, done_z, done_f, done_t;
  logic [2:0]  st_a, st_z, st_f, st_t;

  logic [17:0] mem_a [16];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  la_capture_controller #(.SAMPLE_WIDTH(18), .SAMPLE_DEPTH(16), .TRIGGER_LOC(4)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .trigger(trigger), .sample_in(sample_in),
    .bram_addr(addr_a), .bram_din(din_a), .bram_we(we_a), .read_ptr(rp_a), .state(st_a), .done(done_a));
  la_capture_controller #(.SAMPLE_WIDTH(18), .SAMPLE_DEPTH(16), .TRIGGER_LOC(0)) u_z (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .trigger(trigger), .sample_in(sample_in),
    .bram_addr(addr_z), .bram_din(din_z), .bram_we(we_z), .read_ptr(rp_z), .state(st_z), .done(done_z));
  la_capture_controller #(.SAMPLE_WIDTH(18), .SAMPLE_DEPTH(16), .TRIGGER_LOC(15)) u_f (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .trigger(trigger), .sample_in(sample_in),
    .bram_addr(addr_f), .bram_din(din_f), .bram_we(we_f), .read_ptr(rp_f), .state(st_f), .done(done_f));
  la_capture_controller #(.SAMPLE_WIDTH(18), .SAMPLE_DEPTH(12), .TRIGGER_LOC(4)) u_t (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .trigger(trigger), .sample_in(sample_in),
    .bram_addr(addr_t), .bram_din(din_t), .bram_we(we_t), .read_ptr(rp_t), .state(st_t), .done(done_t));

  // Port A RAM model for the main instance.
  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= din_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    sample_in = sample_in + 18'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; trigger = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (st_a !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st_a); end
    n_cmp++; if (we_a !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %0b want 0", we_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done_a); end
    n_cmp++; if (rp_a !== 4'd0 || addr_a !== 4'd0) begin n_bad++; $display("FAIL reset_ptrs: rp %0d addr %0d want 0 0", rp_a, addr_a); end
    n_cmp++; if ({st_z, st_f, st_t} !== 9'd0 || {we_z, we_f, we_t, done_z, done_f, done_t} !== 6'd0 || {rp_z, rp_f, rp_t} !== 12'd0)
      begin n_bad++; $display("FAIL reset_variants: st %0d/%0d/%0d rp %0d/%0d/%0d want all 0", st_z, st_f, st_t, rp_z, rp_f, rp_t); end
    // Drive into CAPTURING with a non-zero read pointer, then reset.
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    trigger = 1'b1; tick(); trigger = 1'b0;
    tick(); tick();
    n_cmp++; if (st_a !== 3'd3 || rp_a !== 4'd2) begin n_bad++; $display("FAIL pre_reset_capturing: state %0d rp %0d want 3 2", st_a, rp_a); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (st_a !== 3'd0 || we_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL midrun_reset_ctrl: state %0d we %0b done %0b want 0 0 0", st_a, we_a, done_a); end
    n_cmp++; if (rp_a !== 4'd0 || addr_a !== 4'd0) begin n_bad++; $display("FAIL midrun_reset_ptrs: rp %0d addr %0d want 0 0", rp_a, addr_a); end
  endtask

  task automatic test_trigger_held();
    logic [17:0] s0;
    logic [2:0]  exp_st;
    do_reset();
    start = 1'b1; trigger = 1'b1; tick(); start = 1'b0;
    s0 = sample_in;
    for (int k = 0; k < 16; k++) begin
      exp_st = (k < 4) ? 3'd1 : ((k == 4) ? 3'd2 : 3'd3);
      n_cmp++;
      if (we_a !== 1'b1 || addr_a !== 4'(k) || st_a !== exp_st) begin
        n_bad++; $display("FAIL held_write%0d: we %0b addr %0d state %0d want 1 %0d %0d", k, we_a, addr_a, st_a, k, exp_st);
      end
      tick();
    end
    trigger = 1'b0;
    n_cmp++; if (st_a !== 3'd4 || done_a !== 1'b1 || we_a !== 1'b0) begin n_bad++; $display("FAIL held_done: state %0d done %0b we %0b want 4 1 0", st_a, done_a, we_a); end
    n_cmp++; if (rp_a !== 4'd0) begin n_bad++; $display("FAIL held_read_ptr: got %0d want 0", rp_a); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (mem_a[i] !== 18'(s0 + 18'(i))) begin n_bad++; $display("FAIL held_ram%0d: got %0d want %0d", i, mem_a[i], 18'(s0 + 18'(i))); end
    end
  endtask

  task automatic test_wrap_trigger();
    int         n = 0;
    logic [3:0] last = 4'd0;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 80 && st_a != 3'd4; i++) begin
      trigger = (n == 22);
      if (we_a) begin
        if (n == 22) begin
          n_cmp++; if (addr_a !== 4'd6 || st_a !== 3'd2) begin n_bad++; $display("FAIL wrap_trig_addr: addr %0d state %0d want 6 2", addr_a, st_a); end
        end
        last = addr_a;
        n++;
      end
      tick();
    end
    trigger = 1'b0;
    n_cmp++; if (st_a !== 3'd4) begin n_bad++; $display("FAIL wrap_end_state: got %0d want 4", st_a); end
    n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL wrap_write_count: got %0d want 34", n); end
    n_cmp++; if (last !== 4'd1) begin n_bad++; $display("FAIL wrap_last_addr: got %0d want 1", last); end
    n_cmp++; if (rp_a !== 4'd2) begin n_bad++; $display("FAIL wrap_read_ptr: got %0d want 2", rp_a); end
  endtask

  task automatic test_trigger_loc_edges();
    int         n = 0;
    logic [3:0] last = 4'd0;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (st_z !== 3'd2 || addr_z !== 4'd0) begin n_bad++; $display("FAIL tl0_arm: state %0d addr %0d want 2 0", st_z, addr_z); end
    repeat (9) tick();
    n_cmp++; if (addr_z !== 4'd9) begin n_bad++; $display("FAIL tl0_pre_addr: got %0d want 9", addr_z); end
    trigger = 1'b1; tick(); trigger = 1'b0;
    n_cmp++; if (st_z !== 3'd3 || rp_z !== 4'd9) begin n_bad++; $display("FAIL tl0_trigger: state %0d rp %0d want 3 9", st_z, rp_z); end
    for (int i = 0; i < 40 && st_z != 3'd4; i++) begin
      if (we_z) begin last = addr_z; n++; end
      tick();
    end
    n_cmp++; if (last !== 4'd8 || n !== 15 || done_z !== 1'b1) begin n_bad++; $display("FAIL tl0_end: last %0d count %0d done %0b want 8 15 1", last, n, done_z); end
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    repeat (15) tick();
    n_cmp++; if (st_f !== 3'd2 || addr_f !== 4'd15) begin n_bad++; $display("FAIL tl15_in_pos: state %0d addr %0d want 2 15", st_f, addr_f); end
    trigger = 1'b1; tick(); trigger = 1'b0;
    n_cmp++; if (st_f !== 3'd4 || done_f !== 1'b1 || we_f !== 1'b0) begin n_bad++; $display("FAIL tl15_captured: state %0d done %0b we %0b want 4 1 0", st_f, done_f, we_f); end
    n_cmp++; if (rp_f !== 4'd0) begin n_bad++; $display("FAIL tl15_read_ptr: got %0d want 0", rp_f); end
  endtask

  task automatic test_stop();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    n_cmp++; if (st_a !== 3'd2 || addr_a !== 4'd4) begin n_bad++; $display("FAIL stop_pre: state %0d addr %0d want 2 4", st_a, addr_a); end
    stop = 1'b1;
    #1;
    n_cmp++; if (we_a !== 1'b0) begin n_bad++; $display("FAIL stop_same_cycle_we: got %0b want 0", we_a); end
    tick(); stop = 1'b0;
    n_cmp++; if (st_a !== 3'd0 || we_a !== 1'b0 || addr_a !== 4'd4) begin n_bad++; $display("FAIL stop_idle: state %0d we %0b addr %0d want 0 0 4", st_a, we_a, addr_a); end
    repeat (3) tick();
    n_cmp++; if (we_a !== 1'b0 || addr_a !== 4'd4) begin n_bad++; $display("FAIL stop_quiet: we %0b addr %0d want 0 4", we_a, addr_a); end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    n_cmp++; if (st_a !== 3'd0 || we_a !== 1'b0 || addr_a !== 4'd4) begin n_bad++; $display("FAIL start_stop_idle: state %0d we %0b addr %0d want 0 0 4", st_a, we_a, addr_a); end
  endtask

  task automatic test_rearm();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    trigger = 1'b1; tick(); trigger = 1'b0;
    for (int i = 0; i < 40 && st_a != 3'd4; i++) tick();
    n_cmp++; if (st_a !== 3'd4 || done_a !== 1'b1 || addr_a !== 4'd2) begin n_bad++; $display("FAIL rearm_pre: state %0d done %0b addr %0d want 4 1 2", st_a, done_a, addr_a); end
    start = 1'b1;
    #1;
    n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL rearm_done_hold: got %0b want 1", done_a); end
    tick(); start = 1'b0;
    n_cmp++; if (st_a !== 3'd1 || addr_a !== 4'd0 || done_a !== 1'b0 || we_a !== 1'b1) begin n_bad++; $display("FAIL rearm: state %0d addr %0d done %0b we %0b want 1 0 0 1", st_a, addr_a, done_a, we_a); end
    n_cmp++; if (din_z !== sample_in || din_f !== sample_in || din_t !== sample_in) begin n_bad++; $display("FAIL din_passthru: %0d %0d %0d want %0d", din_z, din_f, din_t, sample_in); end
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      n_cmp++;
      if (addr_t !== 4'(i % 12) || we_t !== 1'b1) begin n_bad++; $display("FAIL d12_wrap%0d: addr %0d we %0b want %0d 1", i, addr_t, we_t, i % 12); end
      tick();
    end
    n_cmp++; if (st_t !== 3'd2 || rp_t !== 4'd0) begin n_bad++; $display("FAIL d12_state: state %0d rp %0d want 2 0", st_t, rp_t); end
  endtask

  initial begin
    test_reset();
    test_trigger_held();
    test_wrap_trigger();
    test_trigger_loc_edges();
    test_stop();
    test_rearm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000");
    $fatal(1);
  end

endmodule
